regfile_tagged: RTL and testbench
=================================

// Module: regfile_tagged
// PURPOSE
//   Parametrised architectural register file for the out-of-order core. Each entry carries a
//   value plus a busy bit and reorder-buffer (ROB) tag. Decode reads operands and renames rd;
//   commit writes back and releases the tag; a flush clears all pending renames.
//   Sits between decode/issue (read + rename) and the ROB commit stage (write-back).
// PARAMETERS
//   XLEN      32  data width of each register
//   NREGS     32  number of registers; index 0 is hard-wired zero; AW = $clog2(NREGS) (localparam)
//   TAG_W     4   ROB tag width
//   NUM_READ  2   number of independent read ports
// PORTS
//   clk        in   1                clock, all state updates on rising edge
//   rst        in   1                asynchronous, active-low reset
//   rn_en      in   1                rename request: mark rn_addr busy with rn_tag
//   rn_addr    in   AW               register being renamed
//   rn_tag     in   TAG_W            ROB tag that will produce rn_addr
//   cm_en      in   1                commit write-back valid
//   cm_addr    in   AW               committed destination register
//   cm_tag     in   TAG_W            ROB tag of committing instruction
//   cm_data    in   XLEN             committed value
//   flush      in   1                mispredict flush: clear every busy bit
//   rd_addr    in   NUM_READ*AW      read addresses, port i in bits [i*AW +: AW]
//   rd_data    out  NUM_READ*XLEN    read values (combinational)
//   rd_busy    out  NUM_READ         1 = operand pending, take rd_tag instead of rd_data
//   rd_tag     out  NUM_READ*TAG_W   pending producer tag (0 when not busy)
//   all_idle   out  1                registered; 1 when no register is busy
// BEHAVIOUR
// - Reset (rst=0, async): all values, busy bits, tags <= 0; all_idle <= 1. While rst=0 every
//   rd_* output is 0. Reset mid-operation discards all pending renames and commits.
// - Register 0: reads always return data 0, busy 0, tag 0; rename and commit to 0 are ignored.
// - Commit (cm_en=1, cm_addr!=0): value[cm_addr] <= cm_data unconditionally (also during flush).
//   busy[cm_addr] cleared only if busy=1 and tag==cm_tag (a later rename still owns the reg).
// - Rename (rn_en=1, rn_addr!=0, flush=0): busy <= 1, tag <= rn_tag.
// - Same-cycle rename and commit to the same register: rename wins (busy=1, tag=rn_tag);
//   the value is still written.
// - Flush: all busy bits and tags <= 0 next edge; rn_en in the same cycle is ignored.
// - Reads are combinational, 0-cycle latency, and see pre-edge state with commit bypass:
//   if cm_en=1, cm_addr==rd_addr!=0, entry busy and tag==cm_tag -> rd_data=cm_data, rd_busy=0,
//   rd_tag=0. Otherwise rd_data=value, rd_busy=busy, rd_tag=busy?tag:0.
//   A same-cycle rename never affects reads (an instruction renaming rd=rs sees the old rs).
// - all_idle: registered, reflects next-state busy bits (updates on the same edge as busy).
// - No handshake/backpressure: upstream guarantees at most one rename and one commit per cycle.
// TESTING
//   1. Reset: drive rst=0 mid-run with regs busy -> all rd_busy=0, rd_data=0, all_idle=1 immediately
//      after release.
//   2. Rename x5 tag 3, next cycle read x5 -> rd_busy=1, rd_tag=3; commit x5 tag 3 data
//      0xDEADBEEF -> same-cycle read gives 0xDEADBEEF busy 0; following cycle same from array.
//   3. Rename x7 tag 1, rename x7 tag 2, commit x7 tag 1 data 0x11 -> value 0x11 stored but
//      x7 stays busy with tag 2; commit tag 2 data 0x22 -> busy 0, value 0x22, all_idle=1.
//   4. Same cycle: commit x9 tag 4 (owner) and rename x9 tag 6 -> x9 busy, tag 6, value = cm_data.
//   5. Rename x1..x3, assert flush with rn_en for x4 -> next cycle no reg busy, x4 not busy,
//      all_idle=1, values unchanged.
//   6. Rename/commit to x0 with data 0xFFFFFFFF -> all NUM_READ ports reading x0 return 0, busy 0.

Source files
------------

// File: rtl/regfile_tagged_if.sv
// Bus between decode/issue + ROB commit (master) and the tagged register file (slave).
// Read addresses/results are flat vectors, port i at [i*W +: W].
interface regfile_tagged_if #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int TAG_W    = 4,
  parameter int NUM_READ = 2
);
  localparam int AW = $clog2(NREGS);

  logic                      rn_en;
  logic [AW-1:0]             rn_addr;
  logic [TAG_W-1:0]          rn_tag;
  logic                      cm_en;
  logic [AW-1:0]             cm_addr;
  logic [TAG_W-1:0]          cm_tag;
  logic [XLEN-1:0]           cm_data;
  logic                      flush;
  logic [NUM_READ*AW-1:0]    rd_addr;
  logic [NUM_READ*XLEN-1:0]  rd_data;
  logic [NUM_READ-1:0]       rd_busy;
  logic [NUM_READ*TAG_W-1:0] rd_tag;
  logic                      all_idle;

  modport master (
    output rn_en, rn_addr, rn_tag, cm_en, cm_addr, cm_tag, cm_data, flush, rd_addr,
    input  rd_data, rd_busy, rd_tag, all_idle
  );

  modport slave (
    input  rn_en, rn_addr, rn_tag, cm_en, cm_addr, cm_tag, cm_data, flush, rd_addr,
    output rd_data, rd_busy, rd_tag, all_idle
  );
endinterface

// File: rtl/regfile_tagged.sv
// Tagged architectural register file: value + busy bit + ROB tag per entry.
// Decode reads/renames, commit writes back and releases the tag, flush drops renames.

// One read port: applies the commit bypass and x0 / reset masking to a selected entry.
module regfile_tagged_rdport #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int AW    = 5
) (
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [XLEN-1:0]  val_i,
  input  logic             busy_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             cm_en_i,
  input  logic [AW-1:0]    cm_addr_i,
  input  logic [TAG_W-1:0] cm_tag_i,
  input  logic [XLEN-1:0]  cm_data_i,
  output logic [XLEN-1:0]  data_o,
  output logic             busy_o,
  output logic [TAG_W-1:0] tag_o
);
  logic hit;

  // Bypass when the committing instruction is the current owner of this register.
  always_comb begin
    data_o = '0;
    busy_o = 1'b0;
    tag_o  = '0;
    hit    = cm_en_i && (cm_addr_i == addr_i) && busy_i && (tag_i == cm_tag_i);
    if (en_i && (addr_i != '0)) begin
      if (hit) begin
        data_o = cm_data_i;
      end else begin
        data_o = val_i;
        busy_o = busy_i;
        tag_o  = busy_i ? tag_i : '0;
      end
    end
  end
endmodule

module regfile_tagged #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int TAG_W    = 4,
  parameter int NUM_READ = 2
) (
  input  logic clk,
  input  logic rst,
  regfile_tagged_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0][XLEN-1:0]  value_q, value_d;
  logic [NREGS-1:0]            busy_q,  busy_d;
  logic [NREGS-1:0][TAG_W-1:0] tag_q,   tag_d;
  logic                        all_idle_q;

  logic [NUM_READ-1:0][AW-1:0]    rd_addr_w;
  logic [NUM_READ-1:0][XLEN-1:0]  rd_data_w;
  logic [NUM_READ-1:0]            rd_busy_w;
  logic [NUM_READ-1:0][TAG_W-1:0] rd_tag_w;

  // Next state: commit first, then flush or rename override busy/tag (rename wins on collision).
  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    if (bus.cm_en && (bus.cm_addr != '0)) begin
      value_d[bus.cm_addr] = bus.cm_data;
      if (busy_q[bus.cm_addr] && (tag_q[bus.cm_addr] == bus.cm_tag)) begin
        busy_d[bus.cm_addr] = 1'b0;
        tag_d[bus.cm_addr]  = '0;
      end
    end
    if (bus.flush) begin
      busy_d = '0;
      tag_d  = '0;
    end else if (bus.rn_en && (bus.rn_addr != '0)) begin
      busy_d[bus.rn_addr] = 1'b1;
      tag_d[bus.rn_addr]  = bus.rn_tag;
    end
    // x0 is never busy and always zero.
    value_d[0] = '0;
    busy_d[0]  = 1'b0;
    tag_d[0]   = '0;
  end

  // State registers; all_idle tracks next-state busy so it moves with the busy bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q    <= '0;
      busy_q     <= '0;
      tag_q      <= '0;
      all_idle_q <= 1'b1;
    end else begin
      value_q    <= value_d;
      busy_q     <= busy_d;
      tag_q      <= tag_d;
      all_idle_q <= ~|busy_d;
    end
  end

  assign rd_addr_w = bus.rd_addr;

  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    regfile_tagged_rdport #(.XLEN(XLEN), .TAG_W(TAG_W), .AW(AW)) u_rd (
      .en_i      (rst),
      .addr_i    (rd_addr_w[g]),
      .val_i     (value_q[rd_addr_w[g]]),
      .busy_i    (busy_q[rd_addr_w[g]]),
      .tag_i     (tag_q[rd_addr_w[g]]),
      .cm_en_i   (bus.cm_en),
      .cm_addr_i (bus.cm_addr),
      .cm_tag_i  (bus.cm_tag),
      .cm_data_i (bus.cm_data),
      .data_o    (rd_data_w[g]),
      .busy_o    (rd_busy_w[g]),
      .tag_o     (rd_tag_w[g])
    );
  end

  assign bus.rd_data  = rd_data_w;
  assign bus.rd_busy  = rd_busy_w;
  assign bus.rd_tag   = rd_tag_w;
  assign bus.all_idle = all_idle_q;
endmodule

// File: tb/tb_regfile_tagged.sv
// Directed bench for regfile_tagged: rename/commit/bypass/flush/x0/reset scenarios.
module tb_regfile_tagged;
  localparam int XLEN = 32, NREGS = 32, TAG_W = 4, NUM_READ = 2, AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  regfile_tagged_if #(.XLEN(XLEN), .NREGS(NREGS), .TAG_W(TAG_W), .NUM_READ(NUM_READ)) bus ();

  regfile_tagged #(.XLEN(XLEN), .NREGS(NREGS), .TAG_W(TAG_W), .NUM_READ(NUM_READ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input int p, input logic [31:0] d,
                      input logic b, input logic [3:0] t);
    chk($sformatf("%s.p%0d.data", tag, p), bus.rd_data[p*XLEN +: XLEN], d);
    chk($sformatf("%s.p%0d.busy", tag, p), {31'd0, bus.rd_busy[p]}, {31'd0, b});
    chk($sformatf("%s.p%0d.tag", tag, p), {28'd0, bus.rd_tag[p*TAG_W +: TAG_W]}, {28'd0, t});
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rn_en = 0; bus.cm_en = 0; bus.flush = 0;
  endtask

  task automatic rename(input logic [4:0] a, input logic [3:0] t);
    bus.rn_en = 1; bus.rn_addr = a; bus.rn_tag = t;
  endtask

  task automatic commit(input logic [4:0] a, input logic [3:0] t, input logic [31:0] d);
    bus.cm_en = 1; bus.cm_addr = a; bus.cm_tag = t; bus.cm_data = d;
  endtask

  initial begin
    bus.rn_en = 0; bus.rn_addr = '0; bus.rn_tag = '0;
    bus.cm_en = 0; bus.cm_addr = '0; bus.cm_tag = '0; bus.cm_data = '0;
    bus.flush = 0; bus.rd_addr = '0;

    // Power-on reset
    tick(); tick();
    rd2(5'd5, 5'd7);
    chkp("por", 0, 32'h0, 1'b0, 4'h0);
    chk("por.idle", {31'd0, bus.all_idle}, 32'd1);
    rst = 1'b1;
    tick();

    // Rename x5 tag 3, then commit with same-cycle bypass
    rename(5'd5, 4'd3); tick(); idle();
    rd2(5'd5, 5'd5);
    chkp("ren5", 0, 32'h0, 1'b1, 4'h3);
    chk("ren5.idle", {31'd0, bus.all_idle}, 32'd0);
    commit(5'd5, 4'd3, 32'hDEADBEEF); rd2(5'd5, 5'd5);
    chkp("byp5", 0, 32'hDEADBEEF, 1'b0, 4'h0);
    chkp("byp5", 1, 32'hDEADBEEF, 1'b0, 4'h0);
    tick(); idle(); rd2(5'd5, 5'd5);
    chkp("arr5", 0, 32'hDEADBEEF, 1'b0, 4'h0);
    chk("arr5.idle", {31'd0, bus.all_idle}, 32'd1);

    // Stale commit must not release a register renamed again
    rename(5'd7, 4'd1); tick();
    rename(5'd7, 4'd2); tick(); idle();
    commit(5'd7, 4'd1, 32'h11); rd2(5'd7, 5'd5);
    chkp("stale", 0, 32'h0, 1'b1, 4'h2);
    tick(); idle(); rd2(5'd7, 5'd5);
    chkp("stale.arr", 0, 32'h11, 1'b1, 4'h2);
    chk("stale.idle", {31'd0, bus.all_idle}, 32'd0);
    commit(5'd7, 4'd2, 32'h22); rd2(5'd7, 5'd5);
    chkp("own7", 0, 32'h22, 1'b0, 4'h0);
    tick(); idle(); rd2(5'd7, 5'd5);
    chkp("own7.arr", 0, 32'h22, 1'b0, 4'h0);
    chk("own7.idle", {31'd0, bus.all_idle}, 32'd1);

    // Same-cycle commit (owner) and rename of x9: rename wins, value written
    rename(5'd9, 4'd4); tick(); idle();
    commit(5'd9, 4'd4, 32'h99); rename(5'd9, 4'd6); rd2(5'd9, 5'd9);
    chkp("coll.byp", 1, 32'h99, 1'b0, 4'h0);
    tick(); idle(); rd2(5'd9, 5'd9);
    chkp("coll", 0, 32'h99, 1'b1, 4'h6);
    chk("coll.idle", {31'd0, bus.all_idle}, 32'd0);

    // Flush with pending renames, a same-cycle rename and an unrelated commit
    rename(5'd1, 4'd1); tick();
    rename(5'd2, 4'd2); tick();
    rename(5'd3, 4'd3); tick(); idle();
    rd2(5'd3, 5'd1);
    chkp("pre.fl", 0, 32'h0, 1'b1, 4'h3);
    bus.flush = 1; rename(5'd4, 4'd5); commit(5'd10, 4'd0, 32'h1010);
    tick(); idle();
    rd2(5'd1, 5'd2);
    chkp("fl", 0, 32'h0, 1'b0, 4'h0);
    chkp("fl", 1, 32'h0, 1'b0, 4'h0);
    rd2(5'd3, 5'd4);
    chkp("fl", 0, 32'h0, 1'b0, 4'h0);
    chkp("fl.x4", 1, 32'h0, 1'b0, 4'h0);
    rd2(5'd9, 5'd10);
    chkp("fl.x9", 0, 32'h99, 1'b0, 4'h0);
    chkp("fl.x10", 1, 32'h1010, 1'b0, 4'h0);
    chk("fl.idle", {31'd0, bus.all_idle}, 32'd1);

    // x0 is hard-wired zero
    rename(5'd0, 4'd7); commit(5'd0, 4'd0, 32'hFFFFFFFF); rd2(5'd0, 5'd0);
    chkp("x0", 0, 32'h0, 1'b0, 4'h0);
    chkp("x0", 1, 32'h0, 1'b0, 4'h0);
    tick(); idle(); rd2(5'd0, 5'd0);
    chkp("x0.arr", 0, 32'h0, 1'b0, 4'h0);
    chkp("x0.arr", 1, 32'h0, 1'b0, 4'h0);
    chk("x0.idle", {31'd0, bus.all_idle}, 32'd1);

    // Asynchronous reset mid-run with busy registers and a live commit
    rename(5'd5, 4'd8); tick(); idle();
    chk("mid.idle0", {31'd0, bus.all_idle}, 32'd0);
    commit(5'd5, 4'd8, 32'h55); rd2(5'd5, 5'd7);
    #2 rst = 1'b0; #1;
    chkp("rst", 0, 32'h0, 1'b0, 4'h0);
    chkp("rst", 1, 32'h0, 1'b0, 4'h0);
    chk("rst.idle", {31'd0, bus.all_idle}, 32'd1);
    idle();
    tick(); rst = 1'b1; rd2(5'd5, 5'd7);
    chkp("rel", 0, 32'h0, 1'b0, 4'h0);
    chkp("rel", 1, 32'h0, 1'b0, 4'h0);
    tick(); rd2(5'd5, 5'd7);
    chkp("rel.arr", 0, 32'h0, 1'b0, 4'h0);
    chk("rel.idle", {31'd0, bus.all_idle}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
